// File: rtl/oc_led_pwm.sv
// oc_led_pwm: multi-channel LED PWM driver with per-LED modes
// (off, on, blink, heartbeat, fade, pattern), a shared prescaled
// PWM timebase, frame/step sequencing and frame-start config shadowing.
// Optional macro OC_LED_PWM_GAMMA_EN squares the brightness
// (gamma approximation) through an extra register ahead of the shadow.
module oc_led_pwm #(
  parameter int LedCount = 1,
  parameter int PwmBits  = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [15:0]                  prescale,
  input  logic                         restart,
  input  logic [LedCount*3-1:0]        ledMode,
  input  logic [LedCount*PwmBits-1:0]  ledBright,
  input  logic [LedCount*3-1:0]        ledBlinks,
  input  logic [LedCount*16-1:0]       ledPattern,
  output logic [LedCount-1:0]          ledOut,
  output logic                         frameSync
);

  typedef enum logic [2:0] {
    MODE_OFF, MODE_ON, MODE_BLINK, MODE_HEART,
    MODE_FADE, MODE_PATTERN, MODE_RSVD6, MODE_RSVD7
  } mode_e;

  localparam logic [PwmBits-1:0] TOP = '1;
  localparam logic [PwmBits-1:0] ONE = 1;

  logic [15:0]        presc_cnt;
  logic [PwmBits-1:0] pwm_count;
  logic [PwmBits-1:0] frame_in_step;
  logic [3:0]         step;
  logic               start_q;
  logic               tick;
  logic               frame_wrap;

  logic [LedCount-1:0][2:0]         sh_mode,   cfg_mode;
  logic [LedCount-1:0][PwmBits-1:0] sh_bright, cfg_bright;
  logic [LedCount-1:0][2:0]         sh_blinks, cfg_blinks;
  logic [LedCount-1:0][15:0]        sh_pat,    cfg_pat;
  logic [LedCount-1:0][PwmBits-1:0] bright_src;
  logic [LedCount-1:0]              hi;

  assign tick       = (presc_cnt == prescale);
  assign frame_wrap = tick && (pwm_count == TOP);

  // (x*be)>>PwmBits, truncated
  function automatic logic [PwmBits-1:0] level(input logic [PwmBits-1:0] x,
                                                input logic [PwmBits-1:0] be);
    logic [2*PwmBits-1:0] p;
    p = {{PwmBits{1'b0}}, x} * {{PwmBits{1'b0}}, be};
    return p[2*PwmBits-1:PwmBits];
  endfunction

  // Steps 8..15 mirror steps 7..0: ~step[2:0] is 15-step, ~ramp is N-1-ramp
  function automatic logic [PwmBits-1:0] fade(input logic [3:0]         st,
                                               input logic [PwmBits-1:0] ramp,
                                               input logic [PwmBits-1:0] be);
    logic [2:0]         s;
    logic [PwmBits-1:0] r;
    logic [PwmBits+2:0] pos;
    s   = st[3] ? ~st[2:0] : st[2:0];
    r   = st[3] ? ~ramp    : ramp;
    pos = {s, r};
    return level(pos[PwmBits+2:3], be);
  endfunction

`ifdef OC_LED_PWM_GAMMA_EN
  logic [LedCount-1:0][PwmBits-1:0] bright_pipe;

  // Gamma stage: brightness squared, registered ahead of the shadow load
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < LedCount; i++) begin
      bright_pipe[i] <= level(ledBright[i*PwmBits +: PwmBits],
                              ledBright[i*PwmBits +: PwmBits]);
    end
  end
  assign bright_src = bright_pipe;
`else
  assign bright_src = ledBright;
`endif

  // Timebase: prescaler, PWM counter, frame-in-step and step counters
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      presc_cnt     <= '0;
      pwm_count     <= '0;
      frame_in_step <= '0;
      step          <= '0;
      start_q       <= 1'b1;
      frameSync     <= 1'b0;
    end else begin
      start_q   <= frame_wrap;
      frameSync <= frame_wrap;
      if (tick) begin
        presc_cnt <= '0;
        pwm_count <= pwm_count + ONE;
        if (pwm_count == TOP) begin
          frame_in_step <= frame_in_step + ONE;
          if (frame_in_step == TOP) step <= step + 4'd1;
        end
      end else begin
        presc_cnt <= presc_cnt + 16'd1;
      end
    end
  end

  // Shadow config captured in the first cycle of each frame
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_mode   <= '0;
      sh_bright <= '0;
      sh_blinks <= '0;
      sh_pat    <= '0;
    end else if (start_q) begin
      sh_mode   <= ledMode;
      sh_bright <= bright_src;
      sh_blinks <= ledBlinks;
      sh_pat    <= ledPattern;
    end
  end

  // Frame-start cycle uses the inputs directly so pwmCount=0 already sees the new config
  assign cfg_mode   = start_q ? ledMode    : sh_mode;
  assign cfg_bright = start_q ? bright_src : sh_bright;
  assign cfg_blinks = start_q ? ledBlinks  : sh_blinks;
  assign cfg_pat    = start_q ? ledPattern : sh_pat;

  // Per-LED duty selection and comparison against the PWM counter
  always_comb begin
    hi = '0;
    for (int unsigned i = 0; i < LedCount; i++) begin
      logic [PwmBits-1:0] duty;
      logic [PwmBits-1:0] be;
      be   = cfg_bright[i];
      duty = '0;
      case (mode_e'(cfg_mode[i]))
        MODE_ON:      duty = be;
        MODE_BLINK:   if ((step[3:1] < cfg_blinks[i]) && !step[0]) duty = be;
        MODE_HEART: begin
          case (step)
            4'd0, 4'd2: duty = level(frame_in_step, be);
            4'd1, 4'd3: duty = level(~frame_in_step, be);
            default:    duty = '0;
          endcase
        end
        MODE_FADE:    duty = fade(step, frame_in_step, be);
        MODE_PATTERN: if (cfg_pat[i][step]) duty = be;
        default:      duty = '0;
      endcase
      hi[i] = (duty > pwm_count);
    end
  end

  // Registered LED drive
  always_ff @(posedge clock) begin
    if (reset) ledOut <= '0;
    else       ledOut <= hi;
  end

endmodule

// File: tb/tb_oc_led_pwm.sv
// Directed self-checking bench for oc_led_pwm (PwmBits=4, one LED).
module tb_oc_led_pwm;
  localparam int LC = 1;
  localparam int PB = 4;

`ifdef OC_LED_PWM_GAMMA_EN
  localparam int GAMMA8 = 4;
`else
  localparam int GAMMA8 = 8;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          restart = 1'b0;
  logic [15:0]   prescale = '0;
  logic [2:0]    ledMode = '0;
  logic [3:0]    ledBright = '0;
  logic [2:0]    ledBlinks = '0;
  logic [15:0]   ledPattern = '0;
  logic [0:0]    ledOut;
  logic          frameSync;

  int n_cmp = 0;
  int n_bad = 0;
  int hi, fs, ffs, exp_hi;

  always #5 clock = ~clock;

  oc_led_pwm #(.LedCount(LC), .PwmBits(PB)) dut (
    .clock(clock), .reset(reset), .prescale(prescale), .restart(restart),
    .ledMode(ledMode), .ledBright(ledBright), .ledBlinks(ledBlinks),
    .ledPattern(ledPattern), .ledOut(ledOut), .frameSync(frameSync)
  );

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick1();
    @(posedge clock);
    #1;
  endtask

  // Count high samples, frameSync pulses and index of first pulse over n clocks
  task automatic window(input int n, output int h, output int f, output int first);
    h = 0; f = 0; first = 0;
    for (int k = 1; k <= n; k++) begin
      tick1();
      h += int'(ledOut);
      if (frameSync) begin
        f++;
        if (first == 0) first = k;
      end
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick1();
    restart = 1'b0;
  endtask

  initial begin
    // Reset state
    ledMode = 3'd1; ledBright = 4'd5;
    tick1();
    restart = 1'b1;
    tick1();
    restart = 1'b0;
    check("rst_led", int'(ledOut), 0);
    check("rst_fs", int'(frameSync), 0);

    // First frame after release: 5 highs, frameSync at clock 16
    reset = 1'b0;
    window(16, hi, fs, ffs);
    check("on5_first_hi", hi, 5);
    check("on5_first_fs_pos", ffs, 16);
    window(16, hi, fs, ffs);
    check("on5_hi", hi, 5);
    check("on5_fs_cnt", fs, 1);
    check("on5_fs_pos", ffs, 16);

    ledBright = 4'd15;
    window(16, hi, fs, ffs);
    check("on15_hi", hi, 15);
    ledBright = 4'd0;
    window(16, hi, fs, ffs);
    check("on0_hi", hi, 0);

    // Mid-frame brightness change is deferred to the next frame
    ledBright = 4'd3;
    window(7, hi, fs, ffs);
    check("mid_pre_hi", hi, 3);
    ledBright = 4'd12;
    window(9, hi, fs, ffs);
    check("mid_post_hi", hi, 0);
    window(16, hi, fs, ffs);
    check("mid_next_hi", hi, 12);

    // Off and reserved modes
    ledBright = 4'd15;
    ledMode = 3'd6;
    window(16, hi, fs, ffs);
    check("rsvd6_hi", hi, 0);
    ledMode = 3'd7;
    window(16, hi, fs, ffs);
    check("rsvd7_hi", hi, 0);
    ledMode = 3'd0;
    window(16, hi, fs, ffs);
    check("off_hi", hi, 0);

    // Prescale=1: 32-clock frame, 10 highs
    ledMode = 3'd1; ledBright = 4'd5; prescale = 16'd1;
    do_restart();
    window(32, hi, fs, ffs);
    check("presc1_hi", hi, 10);
    check("presc1_fs_pos", ffs, 32);
    prescale = 16'd0;

    // Blink: blinks=2 lights steps 0 and 2 only
    ledMode = 3'd2; ledBlinks = 3'd2; ledBright = 4'd15;
    do_restart();
    for (int s = 0; s < 16; s++) begin
      window(256, hi, fs, ffs);
      exp_hi = (s == 0 || s == 2) ? 240 : 0;
      check($sformatf("blink_step%0d", s), hi, exp_hi);
      if (s == 0) check("blink_fs_cnt", fs, 16);
    end

    // Pattern 8001, bright 8: steps 0 and 15 only
    ledMode = 3'd5; ledPattern = 16'h8001; ledBright = 4'd8;
    do_restart();
    for (int s = 0; s < 16; s++) begin
      window(256, hi, fs, ffs);
      exp_hi = (s == 0 || s == 15) ? 128 : 0;
      check($sformatf("pat_step%0d", s), hi, exp_hi);
    end

    // Heartbeat: restart at step 9, ramp restarts rising
    ledMode = 3'd3; ledBright = 4'd15;
    do_restart();
    window(9 * 256, hi, fs, ffs);
    window(16, hi, fs, ffs);
    check("hb_step9_hi", hi, 0);
    do_restart();
    window(16, hi, fs, ffs);
    check("hb_f0_hi", hi, 0);
    check("hb_f0_fs_pos", ffs, 16);
    window(16, hi, fs, ffs);
    check("hb_f1_hi", hi, 0);
    window(16, hi, fs, ffs);
    check("hb_f2_hi", hi, 1);
    window(16, hi, fs, ffs);
    check("hb_f3_hi", hi, 2);
    window(16, hi, fs, ffs);
    check("hb_f4_hi", hi, 3);
    window(11 * 16, hi, fs, ffs);
    window(16, hi, fs, ffs);
    check("hb_step1_f0_hi", hi, 14);

    // Fade: step 0 frame 0 dark, step 8 frame 0 near full
    ledMode = 3'd4; ledBright = 4'd15;
    do_restart();
    window(16, hi, fs, ffs);
    check("fade_s0f0_hi", hi, 0);
    window(8 * 256 - 16, hi, fs, ffs);
    window(16, hi, fs, ffs);
    check("fade_s8f0_hi", hi, 14);

    // Gamma: bright 8 -> 4/16 with gamma, 8/16 without
    ledMode = 3'd1; ledBright = 4'd8;
    do_restart();
    window(16, hi, fs, ffs);
    window(16, hi, fs, ffs);
    check("gamma8_hi", hi, GAMMA8);

    // Reset mid-frame abandons the frame; new frame starts clean
    window(5, hi, fs, ffs);
    reset = 1'b1;
    tick1();
    check("midrst_led", int'(ledOut), 0);
    check("midrst_fs", int'(frameSync), 0);
    reset = 1'b0;
    window(16, hi, fs, ffs);
    check("midrst_hi", hi, GAMMA8);
    check("midrst_fs_pos", ffs, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
